// File: rtl/ram_pkg.sv
// Shared definitions for the ram request controller and its response pipe.
// Holds the default geometry, the controller FSM encoding and the request bundle.
// No logic lives here; every consumer imports it with ram_pkg::*.
package ram_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_DEPTH  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/ram_rsp_pipe.sv
// Read response pipe: delays the read marker two stages and then registers ram OUT.
// Latency: rsp_valid_o is high in the third cycle after rd_fire_i is sampled.
// Backpressure: none; one response per accepted read, always delivered in order.
module ram_rsp_pipe
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_fire_i,
  input  logic              rd_err_i,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [DATA_W-1:0] rsp_data_o
);

  logic [1:0]        vld_q;
  logic [1:0]        err_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [DATA_W-1:0] rsp_data_d;

  // Capture ram OUT only when a read reaches the last stage; out-of-range reads return zero.
  always_comb begin
    rsp_data_d = rsp_data_q;
    if (vld_q[1]) begin
      rsp_data_d = err_q[1] ? '0 : ram_dout_i;
    end
  end

  // Shift the read marker along; reset flushes anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      err_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      vld_q       <= {vld_q[0], rd_fire_i};
      err_q       <= {err_q[0], rd_err_i};
      rsp_valid_q <= vld_q[1];
      rsp_err_q   <= vld_q[1] & err_q[1];
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: rtl/ram_req_ctrl.sv
// Request-side controller owning the ram addr/rw/din port, plus a zero-fill clear sequence.
// Latency: ram port registered one edge after accept; read response 3 cycles after accept.
// Backpressure: req_ready drops only while clearing or when clr_start is present.
// Optional RAM_REQ_CTRL_STATS_EN adds saturating wr_count/rd_count outputs.
module ram_req_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              clr_start,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rw,
  output logic [DATA_W-1:0] ram_din,
`ifdef RAM_REQ_CTRL_STATS_EN
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count,
`endif
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  ctrl_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_rw_q, ram_rw_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;

  ram_req_t req;
  logic     in_range;
  logic     xfer;
  logic     rd_fire;

  assign req      = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign in_range = ({1'b0, req.addr} < DEPTH_X);

  // A clear request takes priority over any request offered in the same cycle.
  assign req_ready = (state_q == IDLE) && !clr_start;
  assign xfer      = req_valid && req_ready;
  assign rd_fire   = xfer && !req.we;
  assign busy      = (state_q == CLEAR);

  // Next-state for the FSM and the ram port; rw falls back to read whenever nothing is issued.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    ram_rw_d   = 1'b0;
    ram_din_d  = ram_din_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (req_valid) begin
          ram_addr_d = req.addr;
          ram_din_d  = req.wdata;
          // Out-of-range writes are silently dropped by never asserting rw.
          ram_rw_d   = req.we && in_range;
        end
      end
      CLEAR: begin
        ram_addr_d = cnt_q;
        ram_rw_d   = 1'b1;
        ram_din_d  = '0;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, clear counter and registered ram port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      ram_rw_q   <= 1'b0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_rw_q   <= ram_rw_d;
      ram_din_q  <= ram_din_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_rw   = ram_rw_q;
  assign ram_din  = ram_din_q;

  ram_rsp_pipe #(
    .DATA_W (DATA_W)
  ) u_rsp_pipe (
    .clk         (clk),
    .rst         (rst),
    .rd_fire_i   (rd_fire),
    .rd_err_i    (!in_range),
    .ram_dout_i  (ram_dout),
    .rsp_valid_o (rsp_valid),
    .rsp_err_o   (rsp_err),
    .rsp_data_o  (rsp_data)
  );

`ifdef RAM_REQ_CTRL_STATS_EN
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;

  // Count accepted in-range requests only; clear writes never pass through xfer.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (xfer && in_range && req.we && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
    if (xfer && in_range && !req.we && (rd_cnt_q != 16'hFFFF)) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end
  end

  // Saturating statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
`endif

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl: behavioural 8-word ram, reference memory and expected-response queue.
// Directed scenarios followed by a randomized request/clear mix.
// Responses are checked for exact cycle, data and error flag.
module tb_ram_req_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        clr_start;
  logic        busy;
  logic [7:0]  ram_addr;
  logic        ram_rw;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
`ifdef RAM_REQ_CTRL_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] rd_count;
`endif

  ram_req_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .clr_start (clr_start),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_rw    (ram_rw),
    .ram_din   (ram_din),
`ifdef RAM_REQ_CTRL_STATS_EN
    .wr_count  (wr_count),
    .rd_count  (rd_count),
`endif
    .ram_dout  (ram_dout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem[8];
  logic [31:0] mem[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ram: write when rw, else register OUT; unimplemented addresses return junk.
  always @(posedge clk) begin
    if (ram_rw) begin
      if (ram_addr < 8'd8) mem[ram_addr[2:0]] <= ram_din;
    end else begin
      ram_dout <= (ram_addr < 8'd8) ? mem[ram_addr[2:0]] : (32'hBAD0_0000 | 32'(ram_addr));
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor: exact-cycle match against the expected queue, no spurious pulses,
  // and no ram write may ever target an unimplemented word.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        chk("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
        chk("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
        void'(exp_q.pop_front());
      end else if (rsp_valid) begin
        chk("rsp_spurious", 64'(rsp_valid), 64'(0));
      end
      if (ram_rw) chk("ram_wr_in_range", 64'(ram_addr < 8'd8), 64'(1));
    end
  end

  task automatic model_accept(input logic we, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    if (we) begin
      if (a < 8'd8) ref_mem[a[2:0]] = d;
    end else begin
      e.due  = cyc + 3;
      e.err  = (a >= 8'd8);
      e.data = (a < 8'd8) ? ref_mem[a[2:0]] : 32'h0;
      exp_q.push_back(e);
    end
  endtask

  task automatic cycle_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
      clr_start = 1'b0;
    end
  endtask

  task automatic do_req(input logic we, input logic [7:0] a, input logic [31:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    clr_start = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    #1;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'(1));
    else model_accept(we, a, d);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    clr_start = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_ram_addr", 64'(ram_addr), 64'(0));
    chk("rst_ram_rw", 64'(ram_rw), 64'(0));
    chk("rst_ram_din", 64'(ram_din), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
  endtask

  task automatic do_clear(input logic with_req);
    int waited;
    waited = 0;
    @(negedge clk);
    clr_start = 1'b1;
    req_valid = with_req;
    req_we    = 1'b0;
    req_addr  = 8'd3;
    #1;
    chk("clr_blocks_req", 64'(req_ready), 64'(0));
    for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;
    @(negedge clk);
    clr_start = 1'b0;
    req_valid = 1'b0;
    #1;
    while (busy && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("clr_done", 64'(busy), 64'(0));
  endtask

  task automatic write_all();
    for (int i = 0; i < 8; i++) do_req(1'b1, 8'(i), $urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'd0;
    req_wdata = 32'd0;
    clr_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    apply_reset();

    // Read of a fresh word: exact 3-cycle latency, zero data.
    do_req(1'b0, 8'd5, 32'h0);
    cycle_idle(5);

    // Write two words, read them back to back.
    do_req(1'b1, 8'd0, 32'hAABBCCDD);
    do_req(1'b1, 8'd1, 32'h11223344);
    do_req(1'b0, 8'd0, 32'h0);
    do_req(1'b0, 8'd1, 32'h0);
    cycle_idle(5);

    // Out-of-range write is dropped, out-of-range read reports an error with zero data.
    do_req(1'b1, 8'd9, 32'hDEADBEEF);
    do_req(1'b0, 8'd9, 32'h0);
    cycle_idle(5);

    // Write then immediate read of the same word returns the new data.
    do_req(1'b1, 8'd4, 32'hCAFEF00D);
    do_req(1'b0, 8'd4, 32'h0);
    cycle_idle(5);

    // Fill, then clear with a simultaneous request; watch the clear write sequence.
    for (int i = 0; i < 8; i++) do_req(1'b1, 8'(i), 32'h100 + 32'(i));
    @(negedge clk);
    clr_start = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'd3;
    #1;
    chk("clr_req_ready", 64'(req_ready), 64'(0));
    for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clr_start = 1'b0;
      #1;
      chk("clr_busy", 64'(busy), 64'(1));
      chk("clr_ready_low", 64'(req_ready), 64'(0));
      if (i >= 1) begin
        chk("clr_wr_rw", 64'(ram_rw), 64'(1));
        chk("clr_wr_addr", 64'(ram_addr), 64'(i - 1));
        chk("clr_wr_din", 64'(ram_din), 64'(0));
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("clr_busy_end", 64'(busy), 64'(0));
    chk("clr_wr_rw_last", 64'(ram_rw), 64'(1));
    chk("clr_wr_addr_last", 64'(ram_addr), 64'(7));
    chk("clr_ready_end", 64'(req_ready), 64'(1));
    for (int i = 0; i < 8; i++) do_req(1'b0, 8'(i), 32'h0);
    cycle_idle(5);

    // Read in flight when clear starts still completes; reset in the 4th clear cycle.
    do_req(1'b0, 8'd2, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    clr_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clr_start = 1'b0;
    end
    apply_reset();
    cycle_idle(6);

    // Reset with a read response in flight: the response must never appear.
    do_req(1'b0, 8'd1, 32'h0);
    apply_reset();
    cycle_idle(6);
    write_all();
    cycle_idle(3);

`ifdef RAM_REQ_CTRL_STATS_EN
    apply_reset();
    do_req(1'b1, 8'd1, 32'h1);
    do_req(1'b1, 8'd2, 32'h2);
    do_req(1'b0, 8'd1, 32'h0);
    do_req(1'b1, 8'd3, 32'h3);
    do_req(1'b1, 8'd10, 32'h4);
    do_req(1'b0, 8'd2, 32'h0);
    cycle_idle(4);
    do_clear(1'b0);
    cycle_idle(2);
    chk("stats_wr_count", 64'(wr_count), 64'(3));
    chk("stats_rd_count", 64'(rd_count), 64'(2));
    write_all();
`endif

    // Randomized mix of reads, writes (some out of range), idle gaps and clears.
    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_clear(1'($urandom_range(0, 1)));
      end else if (r < 15) begin
        cycle_idle($urandom_range(1, 3));
      end else begin
        do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 11)), $urandom);
      end
    end
    cycle_idle(6);
    chk("rsp_queue_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
- Request-side controller that sits directly upstream of the 256-address/8-word synchronous ram and owns its addr/rw/din port.
- Accepts single-word read/write requests over a valid/ready handshake and drives the ram one request per cycle.
- Returns read data with an aligned valid strobe, and provides a hardware clear sequence that zero-fills the ram.

Parameters:
- ADDR_W, 8, ram address width.
- DATA_W, 32, data word width.
- DEPTH, 8, number of implemented ram words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data valid, one-cycle pulse per read.
- rsp_data  out  DATA_W  read data.
- rsp_err  out  1  qualifies rsp_valid: read was out of range.
- clr_start  in  1  pulse: start zero-fill of all DEPTH words.
- busy  out  1  high while clearing.
- ram_addr  out  ADDR_W  to ram addr.
- ram_rw  out  1  to ram rw (1 = write).
- ram_din  out  DATA_W  to ram din.
- ram_dout  in  DATA_W  from ram OUT.

Behaviour:
- Reset values: ram_addr=0, ram_rw=0, ram_din=0, rsp_valid=0, rsp_err=0, busy=0. FSM goes to IDLE, clear counter to 0, and the read pipeline is flushed.
- FSM states:
  - IDLE: clr_start -> CLEAR.
  - CLEAR: after writing word DEPTH-1 -> IDLE.
- req_ready = (state==IDLE) && !clr_start, combinational. Clear wins over a simultaneous request, and that request is not accepted.
- Handshake:
  - Transfer on the edge where req_valid && req_ready.
  - Request fields must be held stable while req_valid is high and req_ready is low.
  - Throughput is 1 request per cycle, with no response backpressure.
- Issue:
  - On an accepted request, ram_addr/ram_rw/ram_din are registered at the next edge.
  - With no transfer, ram_rw returns to 0 the next cycle (idle reads are harmless).
- Out-of-range write (addr >= DEPTH): dropped. ram_rw is forced to 0 and no error is reported.
- Read latency:
  - Accept at edge N; ram samples at N+1; OUT is valid after N+1.
  - rsp_valid is high for the cycle after edge N+2 (2-stage valid pipe). rsp_data is registered ram_dout, i.e. latency is 3 cycles from acceptance to rsp_valid.
- Out-of-range read: still flows through the pipe, with rsp_valid=1, rsp_err=1, rsp_data=0.
- Writes produce no response. Ram OUT during write cycles is ignored.
- Back-to-back reads give back-to-back rsp_valid in order. Write-then-read to the same address returns the new data, because the write precedes the read by one ram cycle.
- CLEAR:
  - One write per cycle: ram_rw=1, ram_din=0, ram_addr = counter 0..DEPTH-1.
  - busy=1 from the cycle after clr_start until the last write is issued.
  - clr_start during CLEAR is ignored.
  - Read responses already in the pipe still complete during CLEAR.
- rst mid-CLEAR aborts the sequence; the ram is partially cleared, and that is acceptable.

Optional Feature:
- Macro RAM_REQ_CTRL_STATS_EN.
- Defined: adds outputs wr_count and rd_count, 16 bits each.
  - Incremented on each accepted in-range write / read respectively.
  - Saturate at 16'hFFFF; reset to 0; not incremented by CLEAR writes.
- Undefined: ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Shared package ram_pkg:
  - ADDR_W/DATA_W/DEPTH defaults.
  - FSM state enum ctrl_state_t {IDLE, CLEAR}.
  - Request struct {we, addr, wdata}.
- One natural sub-module, ram_rsp_pipe: the 2-stage valid/err shift register plus the rsp_data register. Everything else stays in ram_req_ctrl.

Test Plan:
- Reset then write addr 0 = 32'hAABBCCDD, addr 1 = 32'h11223344, then read 0 and 1 back-to-back -> rsp_valid on 2 consecutive cycles with data AABBCCDD, 11223344, in order, rsp_err=0.
- Read addr 5 after reset -> rsp_valid exactly 3 cycles after acceptance, rsp_data=0.
- Write addr 9 = 32'hDEADBEEF (DEPTH=8) -> ram_rw never 1 for it. Then read addr 9 -> rsp_valid=1, rsp_err=1, rsp_data=0.
- Fill words 0..7 with 32'h100+i, pulse clr_start with req_valid=1 in the same cycle:
  - req_ready=0 and busy=1 for 8 cycles, with ram writes to addr 0..7 of 0.
  - Reads 0..7 afterwards all return 0.
- Assert rst during the 4th CLEAR cycle with a read response in flight -> all outputs return to reset values immediately, no rsp_valid afterwards, req_ready=1 after rst drops.
- STATS_EN build: 3 in-range writes, 2 reads, 1 out-of-range write, 1 clear -> wr_count=3, rd_count=2.
